// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: issues loads/stores on a req/ack data-memory port and
// drives the registered register-file write port consumed by decode.
module mem_wb_stage #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int MEM_ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    input  logic [DATA_W-1:0]     alu_result_i,
    input  logic [DATA_W-1:0]     store_data_i,
    input  logic [ADDR_W-1:0]     rf_waddr_i,
    input  logic                  rf_we_i,
    input  logic                  mem_we_i,
    input  logic                  mem2rf_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [MEM_ADDR_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0]     dmem_wdata_o,
    input  logic                  dmem_ack_i,
    input  logic [DATA_W-1:0]     dmem_rdata_i,
    output logic [ADDR_W-1:0]     rf_waddr_o,
    output logic [DATA_W-1:0]     rf_wdata_o,
    output logic                  rf_we_o,
    output logic                  busy_o
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t                  state_q, state_d;
    logic                    dmem_req_q, dmem_req_d;
    logic                    dmem_we_q, dmem_we_d;
    logic [MEM_ADDR_W-1:0]   dmem_addr_q, dmem_addr_d;
    logic [DATA_W-1:0]       dmem_wdata_q, dmem_wdata_d;
    logic                    rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]       rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]       rf_wdata_q, rf_wdata_d;
    logic                    pend_load_q, pend_load_d;
    logic [ADDR_W-1:0]       pend_waddr_q, pend_waddr_d;
    logic                    dfr_vld_q, dfr_vld_d;
    logic [ADDR_W-1:0]       dfr_waddr_q, dfr_waddr_d;
    logic [DATA_W-1:0]       dfr_wdata_q, dfr_wdata_d;

    logic completing;
    logic accept;
    logic mem_op;
    logic port_taken;

    assign busy_o     = (state_q == REQ) && !dmem_ack_i;
    assign completing = (state_q == REQ) && dmem_ack_i;
    assign accept     = valid_i && !busy_o;
    assign mem_op     = mem_we_i || mem2rf_i;

    // The write port is taken by a completing load (non-x0) or by a deferred ALU result.
    assign port_taken = (completing && pend_load_q && (pend_waddr_q != '0)) || dfr_vld_q;

    always_comb begin
        state_d      = state_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        pend_load_d  = pend_load_q;
        pend_waddr_d = pend_waddr_q;
        dfr_vld_d    = dfr_vld_q;
        dfr_waddr_d  = dfr_waddr_q;
        dfr_wdata_d  = dfr_wdata_q;

        if (completing) begin
            state_d    = IDLE;
            dmem_req_d = 1'b0;
            if (pend_load_q) begin
                rf_we_d    = (pend_waddr_q != '0);
                rf_waddr_d = pend_waddr_q;
                rf_wdata_d = dmem_rdata_i;
            end
        end else if (dfr_vld_q) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = dfr_waddr_q;
            rf_wdata_d = dfr_wdata_q;
            dfr_vld_d  = 1'b0;
        end

        if (accept) begin
            if (mem_op) begin
                state_d      = REQ;
                dmem_req_d   = 1'b1;
                dmem_we_d    = mem_we_i;
                dmem_addr_d  = alu_result_i[MEM_ADDR_W-1:0];
                dmem_wdata_d = store_data_i;
                pend_load_d  = mem2rf_i && !mem_we_i;
                pend_waddr_d = rf_waddr_i;
            end else if (port_taken) begin
                // Single write port: an ALU result colliding with a load completion
                // (or an older deferred result) is emitted one edge later, in order.
                if (rf_we_i && (rf_waddr_i != '0)) begin
                    dfr_vld_d   = 1'b1;
                    dfr_waddr_d = rf_waddr_i;
                    dfr_wdata_d = alu_result_i;
                end
            end else begin
                rf_we_d    = rf_we_i && (rf_waddr_i != '0);
                rf_waddr_d = rf_waddr_i;
                rf_wdata_d = alu_result_i;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            pend_load_q  <= 1'b0;
            dfr_vld_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            pend_load_q  <= pend_load_d;
            dfr_vld_q    <= dfr_vld_d;
        end
    end

    // Payload registers are qualified by pend_load_q / dfr_vld_q and need no reset.
    always_ff @(posedge clk) begin
        pend_waddr_q <= pend_waddr_d;
        dfr_waddr_q  <= dfr_waddr_d;
        dfr_wdata_q  <= dfr_wdata_d;
    end

    assign dmem_req_o   = dmem_req_q;
    assign dmem_we_o    = dmem_we_q;
    assign dmem_addr_o  = dmem_addr_q;
    assign dmem_wdata_o = dmem_wdata_q;
    assign rf_we_o      = rf_we_q;
    assign rf_waddr_o   = rf_waddr_q;
    assign rf_wdata_o   = rf_wdata_q;

endmodule
